// File: rtl/fltadd_seq.sv
// fltadd_seq: sequential floating-point adder/subtractor with a start/done
// handshake. Exponent/mantissa widths are parameters (default IEEE half).
//
// Ports:
//   clk     - clock, all state on the rising edge
//   reset   - asynchronous active-low reset
//   start   - request, sampled only in IDLE or DONE
//   sub     - 0: a+b, 1: a-b (sign of b inverted at capture)
//   op_a    - operand A {sign, exp, mant}
//   op_b    - operand B {sign, exp, mant}
//   busy    - high in every state except IDLE and DONE
//   done    - high in DONE, held until the next accepted start
//   result  - sum, valid while done=1
//   flags   - {invalid, overflow, inexact, zero}, valid while done=1
module fltadd_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int ROUND = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sub,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;              // hidden + mant + G,R,S
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [EXP_W-1:0] E_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] LIM    = EXP_W'(MAN_W + 3);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, RND, DONE} state_t;

    state_t              r_state;
    logic                r_special, r_inv;
    logic                r_sa, r_sb;            // r_sa: sign of larger operand
    logic [EXP_W-1:0]    r_exp, r_diff;
    logic [MW-1:0]       r_ma, r_mb;
    logic [MW:0]         r_mag;                 // carry + MW
    logic                r_busy, r_done;
    logic [W-1:0]        r_result;
    logic [3:0]          r_flags;

    // ---- unpack at capture ----
    logic                w_sa, w_sb;
    logic [EXP_W-1:0]    w_ea, w_eb, w_ea_eff, w_eb_eff;
    logic [MAN_W-1:0]    w_fa, w_fb;
    logic [MAN_W:0]      w_mfa, w_mfb;
    logic                w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic                w_invalid, w_special, w_a_ge_b;
    logic [W-1:0]        w_spec_res;

    assign w_sa     = op_a[W-1];
    assign w_sb     = op_b[W-1] ^ sub;
    assign w_ea     = op_a[MAN_W +: EXP_W];
    assign w_eb     = op_b[MAN_W +: EXP_W];
    assign w_fa     = op_a[MAN_W-1:0];
    assign w_fb     = op_b[MAN_W-1:0];
    assign w_ea_eff = (w_ea == '0) ? E_ONE : w_ea;
    assign w_eb_eff = (w_eb == '0) ? E_ONE : w_eb;
    assign w_mfa    = {w_ea != '0, w_fa};
    assign w_mfb    = {w_eb != '0, w_fb};
    assign w_a_nan  = (w_ea == E_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == E_ONES) && (w_fb != '0);
    assign w_a_inf  = (w_ea == E_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == E_ONES) && (w_fb == '0);
    assign w_invalid = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb));
    assign w_special = w_invalid || w_a_inf || w_b_inf;
    assign w_a_ge_b  = {w_ea_eff, w_mfa} >= {w_eb_eff, w_mfb};
    assign w_spec_res = w_invalid ? {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}} :
                        w_a_inf   ? {w_sa, E_ONES, {MAN_W{1'b0}}} :
                                    {w_sb, E_ONES, {MAN_W{1'b0}}};

    // ---- rounding / packing of the normalised magnitude ----
    logic [MAN_W:0]      w_m;
    logic                w_g, w_r, w_s, w_inc, w_ovf, w_inexact;
    logic [MAN_W+1:0]    w_m2;
    logic [EXP_W:0]      w_e_fin;
    logic [MAN_W-1:0]    w_man_fin;
    logic [EXP_W-1:0]    w_exp_st;

    assign w_m       = r_mag[MW-1:3];
    assign w_g       = r_mag[2];
    assign w_r       = r_mag[1];
    assign w_s       = r_mag[0];
    assign w_inc     = (ROUND != 0) && w_g && (w_r || w_s || w_m[0]);
    assign w_m2      = {1'b0, w_m} + (MAN_W+2)'(w_inc);
    assign w_e_fin   = {1'b0, r_exp} + (EXP_W+1)'(w_m2[MAN_W+1]);
    assign w_man_fin = w_m2[MAN_W+1] ? w_m2[MAN_W:1] : w_m2[MAN_W-1:0];
    // A hidden bit of 0 here can only occur at exp==1: a subnormal result.
    assign w_exp_st  = w_m2[MAN_W+1] ? w_e_fin[EXP_W-1:0] :
                       (w_m2[MAN_W] ? r_exp : {EXP_W{1'b0}});
    assign w_ovf     = w_e_fin >= {1'b0, E_ONES};
    assign w_inexact = w_g | w_r | w_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_special <= 1'b0;
            r_inv     <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_exp     <= '0;
            r_diff    <= '0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_mag     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else if ((r_state == IDLE || r_state == DONE) && start) begin
            r_state   <= ALIGN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_flags   <= '0;
            r_special <= w_special;
            r_inv     <= w_invalid;
            if (w_special) r_result <= w_spec_res;
            // Keep the larger magnitude in the "a" registers.
            if (w_a_ge_b) begin
                r_sa   <= w_sa;
                r_sb   <= w_sb;
                r_exp  <= w_ea_eff;
                r_ma   <= {w_mfa, 3'b000};
                r_mb   <= {w_mfb, 3'b000};
                r_diff <= w_ea_eff - w_eb_eff;
            end else begin
                r_sa   <= w_sb;
                r_sb   <= w_sa;
                r_exp  <= w_eb_eff;
                r_ma   <= {w_mfb, 3'b000};
                r_mb   <= {w_mfa, 3'b000};
                r_diff <= w_eb_eff - w_ea_eff;
            end
        end else begin
            case (r_state)
                ALIGN: begin
                    if (r_special) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_flags <= {r_inv, 3'b000};
                    end else if (r_diff == '0) begin
                        r_state <= ADD;
                    end else if (r_diff > LIM) begin
                        r_mb    <= {{(MW-1){1'b0}}, |r_mb};
                        r_diff  <= '0;
                        r_state <= ADD;
                    end else begin
                        r_mb   <= {1'b0, r_mb[MW-1:2], r_mb[1] | r_mb[0]};
                        r_diff <= r_diff - E_ONE;
                        if (r_diff == E_ONE) r_state <= ADD;
                    end
                end
                ADD: begin
                    r_mag   <= (r_sa == r_sb) ? ({1'b0, r_ma} + {1'b0, r_mb})
                                              : ({1'b0, r_ma} - {1'b0, r_mb});
                    r_state <= NORM;
                end
                NORM: begin
                    if (r_mag[MW]) begin
                        r_mag   <= {1'b0, r_mag[MW:2], r_mag[1] | r_mag[0]};
                        r_exp   <= r_exp + E_ONE;
                        r_state <= RND;
                    end else if ((r_mag != '0) && !r_mag[MW-1] && (r_exp != E_ONE)) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - E_ONE;
                    end else begin
                        r_state <= RND;
                    end
                end
                RND: begin
                    if (r_mag == '0) begin
                        r_result <= {r_sa & r_sb, {(W-1){1'b0}}};
                        r_flags  <= 4'b0001;
                    end else if (w_ovf) begin
                        r_result <= {r_sa, E_ONES, {MAN_W{1'b0}}};
                        r_flags  <= 4'b0110;
                    end else begin
                        r_result <= {r_sa, w_exp_st, w_man_fin};
                        r_flags  <= {2'b00, w_inexact, 1'b0};
                    end
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                IDLE, DONE: ;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_fltadd_seq.sv
// tb_fltadd_seq: drives two fltadd_seq instances (round-to-nearest-even and
// truncate) with directed and random half-precision operands; results are
// compared against an exact-arithmetic reference model.
module tb_fltadd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy1, done1, busy0, done0;
    logic [15:0] res1, res0;
    logic [3:0]  fl1, fl0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fltadd_seq #(.EXP_W(5), .MAN_W(10), .ROUND(1)) u_rne (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1),
        .result(res1), .flags(fl1)
    );

    fltadd_seq #(.EXP_W(5), .MAN_W(10), .ROUND(0)) u_trn (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0),
        .result(res0), .flags(fl0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact sum in units of the smallest subnormal, then rounded to format.
    function automatic void ref_add(input logic [15:0] a, input logic [15:0] b,
                                    input logic s, input bit rnd,
                                    output logic [15:0] res, output logic [3:0] fl);
        bit     sa, sb, sign, inex;
        int     ea, eb, ma, mb, msb, sh, e;
        longint va, vb, sum, m, q, rem, half;
        sa = a[15]; sb = b[15] ^ s;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0) ||
            (ea == 31 && eb == 31 && sa != sb)) begin
            res = 16'h7E00; fl = 4'b1000; return;
        end
        if (ea == 31) begin res = {sa, 15'h7C00}; fl = 4'b0000; return; end
        if (eb == 31) begin res = {sb, 15'h7C00}; fl = 4'b0000; return; end
        va = (ea == 0) ? longint'(ma) : (longint'(ma + 1024) << (ea - 1));
        vb = (eb == 0) ? longint'(mb) : (longint'(mb + 1024) << (eb - 1));
        sum = (sa ? -va : va) + (sb ? -vb : vb);
        if (sum == 0) begin
            res = {sa & sb, 15'h0000}; fl = 4'b0001; return;
        end
        sign = (sum < 0);
        m = sign ? -sum : sum;
        msb = 0;
        for (int i = 0; i < 48; i++) if (((m >> i) & 1) == 1) msb = i;
        sh = (msb > 10) ? msb - 10 : 0;
        e  = sh + 1;
        q  = m >> sh;
        rem = m - (q << sh);
        inex = (rem != 0);
        if (rnd && sh > 0) begin
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
        end
        if (q == 2048) begin q = q >> 1; e = e + 1; end
        if (e >= 31) begin
            res = {sign, 15'h7C00}; fl = 4'b0110;
        end else begin
            res = {sign, (q >= 1024) ? 5'(e) : 5'd0, 10'(q)};
            fl  = {2'b00, inex, 1'b0};
        end
    endfunction

    // Start one operation; lat = cycles from the start edge until done is seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int lat);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy1), 32'd1);
        check("done_after_start", 32'(done1), 32'd0);
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (done1) begin lat = k; break; end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        check("done_trn", 32'(done0), 32'd1);
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        s;
        logic [15:0] r1;
        logic [3:0]  f1;
        logic [15:0] r0;
        logic [3:0]  f0;
    } vec_t;

    vec_t dir[9];

    initial begin
        int          lat;
        logic [15:0] a, b, er1, er0;
        logic [3:0]  ef1, ef0;
        logic        s;

        dir[0] = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 16'h4000, 4'b0000};
        dir[1] = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0001, 16'h0000, 4'b0001};
        dir[2] = '{16'h4900, 16'hC500, 1'b0, 16'h4500, 4'b0000, 16'h4500, 4'b0000};
        dir[3] = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0110, 16'h7C00, 4'b0110};
        dir[4] = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0010, 16'h3C00, 4'b0010};
        dir[5] = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0010, 16'h3C01, 4'b0010};
        dir[6] = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000, 16'h7E00, 4'b1000};
        dir[7] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000, 16'h7E00, 4'b1000};
        dir[8] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 16'h0002, 4'b0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy1), 32'd0);
        check("rst_done",   32'(done1), 32'd0);
        check("rst_result", 32'(res1),  32'd0);
        check("rst_flags",  32'(fl1),   32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        for (int i = 0; i < 9; i++) begin
            run_op(dir[i].a, dir[i].b, dir[i].s, lat);
            check($sformatf("dir%0d_res_rne", i),   32'(res1), 32'(dir[i].r1));
            check($sformatf("dir%0d_flags_rne", i), 32'(fl1),  32'(dir[i].f1));
            check($sformatf("dir%0d_res_trn", i),   32'(res0), 32'(dir[i].r0));
            check($sformatf("dir%0d_flags_trn", i), 32'(fl0),  32'(dir[i].f0));
            if (i == 0) check("latency_min", 32'(lat), 32'd4);
        end

        // Reset during ALIGN aborts the operation
        @(negedge clk);
        op_a = 16'h5000; op_b = 16'h0400; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_busy_before", 32'(busy1), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy",   32'(busy1), 32'd0);
        check("abort_done",   32'(done1), 32'd0);
        check("abort_result", 32'(res1),  32'd0);
        check("abort_flags",  32'(fl1),   32'd0);
        check("abort_busy_trn", 32'(busy0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(16'h3C00, 16'h3C00, 1'b0, lat);
        check("post_abort_res", 32'(res1), 32'h4000);
        check("post_abort_lat", 32'(lat),  32'd4);

        // Random operands against the reference model
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                1: b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3));
                2: a[14:10] = 5'd0;
                3: b[14:0]  = a[14:0] ^ 15'($urandom_range(0, 7));
                default: ;
            endcase
            ref_add(a, b, s, 1'b1, er1, ef1);
            ref_add(a, b, s, 1'b0, er0, ef0);
            run_op(a, b, s, lat);
            check($sformatf("rnd_res_rne %h%s%h", a, s ? "-" : "+", b), 32'(res1), 32'(er1));
            check($sformatf("rnd_flg_rne %h%s%h", a, s ? "-" : "+", b), 32'(fl1),  32'(ef1));
            check($sformatf("rnd_res_trn %h%s%h", a, s ? "-" : "+", b), 32'(res0), 32'(er0));
            check($sformatf("rnd_flg_trn %h%s%h", a, s ? "-" : "+", b), 32'(fl0),  32'(ef0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
